// File: rtl/eval_pkg.sv
// Types and constants shared between the eval stage and its operand feeder.
package eval_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              kernel;
  } op_entry_t;

endpackage

// File: rtl/eval_op_fifo.sv
// Synchronous FIFO of op_entry_t with occupancy count; read data is shown
// combinationally from the head entry.
module eval_op_fifo
  import eval_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  op_entry_t              i_wdata,
  output op_entry_t              o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  op_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eval_operand_feeder.sv
// Operand feeder for the eval stage: buffers (a, b, kernel) entries, issues one
// per cycle, and gates the eval-stage clock through an IDLE/WAKE/ACTIVE controller.
module eval_operand_feeder
  import eval_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_W-1:0]           i_in_a,
  input  logic [DATA_W-1:0]           i_in_b,
  input  logic                        i_in_kernel,
  output logic [DATA_W-1:0]           o_data_in1,
  output logic [DATA_W-1:0]           o_data_in2,
  output logic                        o_kernel_enable,
  output logic                        o_issue_valid,
  output logic                        o_result_valid,
  output logic                        o_stage_clk_en,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int             IC_W    = $clog2(IDLE_TIMEOUT);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_TIMEOUT - 1);

  feeder_state_t   r_state;
  feeder_state_t   w_state_nxt;
  logic [IC_W-1:0] r_idle_cnt;

  op_entry_t   w_wdata;
  op_entry_t   w_rdata;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_pop;

  logic [DATA_W-1:0] r_data_in1;
  logic [DATA_W-1:0] r_data_in2;
  logic              r_kernel_enable;
  logic              r_issue_valid;
  logic              r_result_valid;

  assign w_wdata    = '{a: i_in_a, b: i_in_b, kernel: i_in_kernel};
  // Ready stays low while reset is held so nothing is offered a handshake then.
  assign o_in_ready = !rst && !w_fifo_full;
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = (r_state == ACTIVE) && !w_fifo_empty;

  eval_op_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty) w_state_nxt = WAKE;
      WAKE:    w_state_nxt = ACTIVE;
      ACTIVE:  if (w_fifo_empty && (r_idle_cnt == IC_LAST)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state != ACTIVE) || !w_fifo_empty || (r_idle_cnt == IC_LAST)) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + IC_W'(1);
      end
    end
  end

  // Operands hold between issues so the eval inputs do not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_in1      <= '0;
      r_data_in2      <= '0;
      r_kernel_enable <= 1'b0;
      r_issue_valid   <= 1'b0;
      r_result_valid  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_data_in1      <= w_rdata.a;
        r_data_in2      <= w_rdata.b;
        r_kernel_enable <= w_rdata.kernel;
        r_issue_valid   <= 1'b1;
      end else begin
        r_kernel_enable <= 1'b0;
        r_issue_valid   <= 1'b0;
      end
      r_result_valid <= r_issue_valid;
    end
  end

  assign o_data_in1      = r_data_in1;
  assign o_data_in2      = r_data_in2;
  assign o_kernel_enable = r_kernel_enable;
  assign o_issue_valid   = r_issue_valid;
  assign o_result_valid  = r_result_valid;
  assign o_stage_clk_en  = (r_state != IDLE);

endmodule

// File: tb/tb_eval_operand_feeder.sv
// Directed bench for eval_operand_feeder: a depth-4 instance for the main
// sequences and a depth-2 instance where the full condition is reachable.
module tb_eval_operand_feeder;
  import eval_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              k;
    logic [DATA_W-1:0] expD1;
    logic [DATA_W-1:0] expD2;
    logic              expK;
  } vec_t;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              k;
  } issue_t;

  logic clk;
  logic rst;

  logic                      inValid, inKernel, inReady;
  logic [DATA_W-1:0]         inA, inB, dataIn1, dataIn2;
  logic                      kernelEnable, issueValid, resultValid, stageClkEn;
  logic [$clog2(DEPTH):0]    fifoCount;

  logic                      sValid, sKernel, sReady;
  logic [DATA_W-1:0]         sA, sB, sD1, sD2;
  logic                      sK, sIssue, sResult, sClkEn;
  logic [1:0]                sCount;

  int     checkCount = 0;
  int     errorCount = 0;
  int     resCount   = 0;
  int     kernelLeak = 0;
  issue_t monQ[$];
  vec_t   streamVec[10];

  eval_operand_feeder #(.FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(inValid), .o_in_ready(inReady),
    .i_in_a(inA), .i_in_b(inB), .i_in_kernel(inKernel),
    .o_data_in1(dataIn1), .o_data_in2(dataIn2),
    .o_kernel_enable(kernelEnable), .o_issue_valid(issueValid),
    .o_result_valid(resultValid), .o_stage_clk_en(stageClkEn),
    .o_fifo_count(fifoCount)
  );

  eval_operand_feeder #(.FIFO_DEPTH(2), .IDLE_TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .rst(rst),
    .i_in_valid(sValid), .o_in_ready(sReady),
    .i_in_a(sA), .i_in_b(sB), .i_in_kernel(sKernel),
    .o_data_in1(sD1), .o_data_in2(sD2),
    .o_kernel_enable(sK), .o_issue_valid(sIssue),
    .o_result_valid(sResult), .o_stage_clk_en(sClkEn),
    .o_fifo_count(sCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every issued entry of the depth-4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (issueValid) monQ.push_back('{dataIn1, dataIn2, kernelEnable});
    if (resultValid) resCount++;
    if (!issueValid && kernelEnable) kernelLeak++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic k, input logic v);
    inA      = a;
    inB      = b;
    inKernel = k;
    inValid  = v;
  endtask

  // Called just after the edge that issued the last entry; expects IDLE 8 edges later.
  task automatic checkTimeout(input string tag, input int alreadyTicked);
    logic awake;
    awake = 1'b1;
    for (int i = alreadyTicked + 1; i <= TIMEOUT - 1; i++) begin
      tick();
      if (!stageClkEn) awake = 1'b0;
    end
    checkOutput({tag, "_awake"}, awake, 1'b1);
    tick();
    checkOutput({tag, "_idle"}, stageClkEn, 1'b0);
  endtask

  initial begin
    logic awake;
    int   waited;

    streamVec = '{
      '{8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0},
      '{8'h01, 8'hFE, 1'b1, 8'h01, 8'hFE, 1'b1},
      '{8'h02, 8'hFD, 1'b0, 8'h02, 8'hFD, 1'b0},
      '{8'h03, 8'hFC, 1'b1, 8'h03, 8'hFC, 1'b1},
      '{8'h04, 8'hFB, 1'b0, 8'h04, 8'hFB, 1'b0},
      '{8'h05, 8'hFA, 1'b1, 8'h05, 8'hFA, 1'b1},
      '{8'h06, 8'hF9, 1'b0, 8'h06, 8'hF9, 1'b0},
      '{8'h07, 8'hF8, 1'b1, 8'h07, 8'hF8, 1'b1},
      '{8'h08, 8'hF7, 1'b0, 8'h08, 8'hF7, 1'b0},
      '{8'h09, 8'hF6, 1'b1, 8'h09, 8'hF6, 1'b1}
    };

    rst = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    sValid = 1'b0; sA = '0; sB = '0; sKernel = 1'b0;
    tick();
    tick();

    // Reset values while reset is held, then ready once released.
    checkOutput("rst_in_ready", inReady, 1'b0);
    checkOutput("rst_issue_valid", issueValid, 1'b0);
    checkOutput("rst_result_valid", resultValid, 1'b0);
    checkOutput("rst_stage_clk_en", stageClkEn, 1'b0);
    checkOutput("rst_fifo_count", fifoCount, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", inReady, 1'b1);

    // Single entry from IDLE: WAKE, then a pop cycle, then issue and result.
    applyStimulus(8'h05, 8'h0F, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t2_count_after_push", fifoCount, 1);
    checkOutput("t2_still_idle", stageClkEn, 1'b0);
    tick();
    checkOutput("t2_wake_clk_en", stageClkEn, 1'b1);
    checkOutput("t2_wake_no_issue", issueValid, 1'b0);
    tick();
    checkOutput("t2_wake_no_pop", fifoCount, 1);
    tick();
    checkOutput("t2_issue_valid", issueValid, 1'b1);
    checkOutput("t2_data_in1", dataIn1, 8'h05);
    checkOutput("t2_data_in2", dataIn2, 8'h0F);
    checkOutput("t2_kernel", kernelEnable, 1'b1);
    checkOutput("t2_count_drained", fifoCount, 0);
    tick();
    checkOutput("t2_result_valid", resultValid, 1'b1);
    checkOutput("t2_kernel_cleared", kernelEnable, 1'b0);
    checkOutput("t2_issue_dropped", issueValid, 1'b0);
    checkOutput("t2_data_hold", dataIn1, 8'h05);
    checkTimeout("t4a", 1);

    // Timeout window interrupted by a push four edges after the last issue.
    applyStimulus(8'h21, 8'h22, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("t4b_first_issue", dataIn1, 8'h21);
    awake = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!stageClkEn) awake = 1'b0;
    end
    applyStimulus(8'h44, 8'h55, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    if (!stageClkEn) awake = 1'b0;
    checkOutput("t4b_count", fifoCount, 1);
    tick();
    if (!stageClkEn) awake = 1'b0;
    checkOutput("t4b_stayed_awake", awake, 1'b1);
    checkOutput("t4b_issue_valid", issueValid, 1'b1);
    checkOutput("t4b_data_in1", dataIn1, 8'h44);
    checkOutput("t4b_kernel", kernelEnable, 1'b1);
    checkTimeout("t4b", 0);

    // Depth-2 instance: fill to full in IDLE/WAKE, full blocks a push even with a pop.
    sValid = 1'b1; sA = 8'h10; sB = 8'h90; sKernel = 1'b1;
    tick();
    checkOutput("t3_count1", sCount, 1);
    sA = 8'h11; sB = 8'h91; sKernel = 1'b0;
    tick();
    checkOutput("t3_full_count", sCount, 2);
    checkOutput("t3_full_ready", sReady, 1'b0);
    sA = 8'h12; sB = 8'h92; sKernel = 1'b1;
    tick();
    checkOutput("t3_held_count", sCount, 2);
    tick();
    checkOutput("t3_issue0_d1", sD1, 8'h10);
    checkOutput("t3_issue0_k", sK, 1'b1);
    checkOutput("t3_full_blocks_push", sCount, 1);
    tick();
    sValid = 1'b0;
    checkOutput("t3_issue1_d1", sD1, 8'h11);
    checkOutput("t3_issue1_k", sK, 1'b0);
    checkOutput("t3_push_pop_count", sCount, 1);
    tick();
    checkOutput("t3_issue2_d1", sD1, 8'h12);
    checkOutput("t3_issue2_d2", sD2, 8'h92);
    checkOutput("t3_drained", sCount, 0);

    // Push with a simultaneous pop at count 2 keeps count and order.
    monQ.delete();
    resCount = 0;
    applyStimulus(8'h31, 8'hC1, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h32, 8'hC2, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("t5_count_before", fifoCount, 2);
    applyStimulus(8'h33, 8'hC3, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_count_hold", fifoCount, 2);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t5_issue_count", monQ.size(), 3);
    if (monQ.size() == 3) begin
      checkOutput("t5_order0", monQ[0].d1, 8'h31);
      checkOutput("t5_order1", monQ[1].d1, 8'h32);
      checkOutput("t5_order2", monQ[2].d1, 8'h33);
      checkOutput("t5_k2", monQ[2].k, 1'b1);
    end
    checkOutput("t5_results", resCount, 3);

    // Ten-entry stream through the wrapping pointers.
    monQ.delete();
    resCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(streamVec[i].a, streamVec[i].b, streamVec[i].k, 1'b1);
      waited = 0;
      while (!inReady && waited < 10) begin
        tick();
        waited++;
      end
      tick();
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    waited = 0;
    while (monQ.size() < 10 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    tick();
    checkOutput("t6_issue_count", monQ.size(), 10);
    for (int i = 0; i < 10 && i < monQ.size(); i++) begin
      checkOutput($sformatf("t6_d1_%0d", i), monQ[i].d1, streamVec[i].expD1);
      checkOutput($sformatf("t6_d2_%0d", i), monQ[i].d2, streamVec[i].expD2);
      checkOutput($sformatf("t6_k_%0d", i), monQ[i].k, streamVec[i].expK);
    end
    checkOutput("t6_results", resCount, 10);
    checkOutput("t6_drained", fifoCount, 0);

    // Reset mid-stream with three entries queued in ACTIVE.
    waited = 0;
    while (stageClkEn && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("t1_idle_first", stageClkEn, 1'b0);
    applyStimulus(8'h71, 8'h81, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h72, 8'h82, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h73, 8'h83, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_queued", fifoCount, 3);
    checkOutput("t1_active", stageClkEn, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t1_count", fifoCount, 0);
    checkOutput("t1_in_ready", inReady, 1'b0);
    checkOutput("t1_clk_en", stageClkEn, 1'b0);
    checkOutput("t1_data_in1", dataIn1, 8'h00);
    checkOutput("t1_data_in2", dataIn2, 8'h00);
    checkOutput("t1_issue", issueValid, 1'b0);
    checkOutput("t1_result", resultValid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t1_release_ready", inReady, 1'b1);
    awake = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stageClkEn || issueValid || (fifoCount != 0)) awake = 1'b1;
    end
    checkOutput("t1_contents_discarded", awake, 1'b0);

    checkOutput("kernel_gating", kernelLeak, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
